keypad_entry_ctrl: RTL

//  Entry sequencer between the 4x4 keypad scanner and the operand datapath.
//  - Debounces the scanner's decoded key code.
//  - Turns each stable press into a single key event.
//  - Runs an FSM that steers digits into operand A, then operand B.
//  - Supports NEXT/BACK/CLEAR keys and generates the operand-select line, replacing a manual select switch.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/key_debounce.sv | 46 ++++
 rtl/keypad_entry_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and state encoding for the keypad entry sequencer.
package keypad_pkg;

  localparam logic [3:0] KEY_NEXT = 4'hA;
  localparam logic [3:0] KEY_BACK = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the scanner's {key_hit,key_code} and emits one key_evt per stable press.
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_hit,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] evt_code
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [4:0]    smp;
  logic [CW-1:0] cnt;
  logic          pressed;
  logic          stable;

  assign stable   = (cnt == CNT_MAX);
  // The event is combinational so the FSM commits it on the very next edge.
  assign key_evt  = stable && smp[4] && !pressed;
  assign evt_code = smp[3:0];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp     <= '0;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      smp <= {key_hit, key_code};
      if ({key_hit, key_code} == smp) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (key_evt)
        pressed <= 1'b1;
      else if (stable && !smp[4])
        pressed <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Entry sequencer: debounced key events drive an FSM that fills operand A then operand B.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int DIGITS     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_code,
  input  logic                  key_hit,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  output logic                  num_sel,
  output logic                  entry_done,
  output logic [1:0]            state
);

  localparam int W = 4 * DIGITS;

  logic       key_evt;
  logic [3:0] evt_code;
  state_t     state_q;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .key_hit  (key_hit),
    .key_code (key_code),
    .key_evt  (key_evt),
    .evt_code (evt_code)
  );

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ENTER_A;
      op_a       <= '0;
      op_b       <= '0;
      num_sel    <= 1'b0;
      entry_done <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      if (key_evt) begin
        if (evt_code == KEY_CLR) begin
          op_a    <= '0;
          op_b    <= '0;
          state_q <= ST_ENTER_A;
          num_sel <= 1'b0;
        end else begin
          case (state_q)
            ST_ENTER_A: begin
              if (is_digit(evt_code)) op_a <= {op_a[W-5:0], evt_code};
              else if (evt_code == KEY_BACK) op_a <= {4'h0, op_a[W-1:4]};
              else if (evt_code == KEY_NEXT) begin
                state_q <= ST_ENTER_B;
                num_sel <= 1'b1;
              end
            end
            ST_ENTER_B: begin
              if (is_digit(evt_code)) op_b <= {op_b[W-5:0], evt_code};
              else if (evt_code == KEY_BACK) op_b <= {4'h0, op_b[W-1:4]};
              else if (evt_code == KEY_NEXT) begin
                state_q    <= ST_DONE;
                entry_done <= 1'b1;
              end
            end
            ST_DONE: begin
              // A digit after completion starts a fresh entry with that digit.
              if (is_digit(evt_code)) begin
                op_a    <= W'(evt_code);
                op_b    <= '0;
                state_q <= ST_ENTER_A;
                num_sel <= 1'b0;
              end
            end
            default: begin
              state_q <= ST_ENTER_A;
              num_sel <= 1'b0;
            end
          endcase
        end
      end else if (state_q != ST_ENTER_A && state_q != ST_ENTER_B && state_q != ST_DONE) begin
        state_q <= ST_ENTER_A;
        num_sel <= 1'b0;
      end
    end
  end

endmodule
